// File: rtl/fphub_sqrt_iter_if.sv
// Issue-side bundle for the HUB square-root unit: request/operand in, result/status out.
interface fphub_sqrt_iter_if #(
    parameter int M = 23,
    parameter int E = 8
);
    localparam int T = M + E;

    logic         start;
    logic [T:0]   x;
    logic [T:0]   res;
    logic         finish;
    logic         computing;
    logic         invalid;

    modport master (
        output start, x,
        input  res, finish, computing, invalid
    );

    modport slave (
        input  start, x,
        output res, finish, computing, invalid
    );
endinterface

// File: rtl/fphub_sqrt_iter.sv
// Sequential HUB floating-point square root, one root bit per clock via restoring recurrence.
// Special operands (zero, negative, Inf, NaN) bypass the recurrence through a one-cycle SPEC state.
module fphub_sqrt_iter #(
    parameter int M = 23,
    parameter int E = 8
) (
    input  logic               clk,
    input  logic               rst_l,
    fphub_sqrt_iter_if.slave   io
);
    localparam int T    = M + E;
    localparam int BIAS = (1 << (E - 1)) - 1;
    localparam int IT   = M + 1;
    localparam int CW   = $clog2(IT);

    localparam logic signed [E:0] BIAS_W = (E + 1)'(BIAS);
    localparam logic [CW-1:0]     LAST   = CW'(IT - 1);
    localparam logic [T:0]        NAN_W  = {1'b0, {E{1'b1}}, 1'b1, {(M - 1){1'b0}}};
    localparam logic [T:0]        INF_W  = {1'b0, {E{1'b1}}, {M{1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, SPEC, DONE} state_t;

    state_t            state_q, state_d;
    logic [T:0]        x_q, x_d;
    logic              loaded_q, loaded_d;
    logic [2*M+1:0]    rad_q, rad_d;
    logic [M+2:0]      rem_q, rem_d;
    logic [M:0]        root_q, root_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [E-1:0]      rexp_q, rexp_d;
    logic [T:0]        res_q, res_d;
    logic              inv_q, inv_d;

    logic              accept;
    logic              in_special;
    logic [E-1:0]      in_exp;
    logic              op_sign;
    logic [E-1:0]      op_exp;
    logic [M-1:0]      op_man;
    logic [T:0]        spec_res;
    logic              spec_inv;
    logic signed [E:0] e_s, e_even, e_half;
    logic              odd;
    logic [M+1:0]      sig;
    logic [2*M+1:0]    rad_init;
    logic [E-1:0]      rexp_init;
    logic [M+4:0]      acc;
    logic [M+2:0]      sub;
    logic              take;
    logic [M:0]        root_next;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q  <= IDLE;
            x_q      <= '0;
            loaded_q <= 1'b0;
            rad_q    <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            cnt_q    <= '0;
            rexp_q   <= '0;
            res_q    <= '0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            loaded_q <= loaded_d;
            rad_q    <= rad_d;
            rem_q    <= rem_d;
            root_q   <= root_d;
            cnt_q    <= cnt_d;
            rexp_q   <= rexp_d;
            res_q    <= res_d;
            inv_q    <= inv_d;
        end
    end

    // Only the exponent and sign are needed to steer the request; the operand itself is registered first.
    always_comb begin
        in_exp     = io.x[T-1:M];
        in_special = (&in_exp) || (in_exp == '0) || io.x[T];
        accept     = ((state_q == IDLE) || (state_q == DONE)) && io.start;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (io.start)
                    state_d = in_special ? SPEC : ITER;
                else
                    state_d = IDLE;
            end
            ITER:    if (loaded_q && (cnt_q == LAST)) state_d = DONE;
            SPEC:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_sign = x_q[T];
        op_exp  = x_q[T-1:M];
        op_man  = x_q[M-1:0];

        if ((&op_exp) && (op_man != '0)) begin
            spec_res = NAN_W;
            spec_inv = 1'b1;
        end else if (op_exp == '0) begin
            spec_res = {op_sign, {T{1'b0}}};
            spec_inv = 1'b0;
        end else if (op_sign) begin
            spec_res = NAN_W;
            spec_inv = 1'b1;
        end else begin
            spec_res = INF_W;
            spec_inv = 1'b0;
        end

        // An odd unbiased exponent is folded into the radicand so the root exponent is an exact halving.
        e_s       = $signed({1'b0, op_exp}) - BIAS_W;
        odd       = e_s[0];
        e_even    = e_s - $signed({{E{1'b0}}, odd});
        e_half    = e_even >>> 1;
        rexp_init = E'(e_half + BIAS_W);
        sig       = {1'b1, op_man, 1'b1};
        rad_init  = odd ? ({{M{1'b0}}, sig} << M) : ({{M{1'b0}}, sig} << (M - 1));

        acc       = {rem_q, rad_q[2*M+1:2*M]};
        sub       = {root_q, 2'b01};
        take      = (acc >= {2'b00, sub});
        root_next = {root_q[M-1:0], take};
    end

    always_comb begin
        x_d      = x_q;
        loaded_d = loaded_q;
        rad_d    = rad_q;
        rem_d    = rem_q;
        root_d   = root_q;
        cnt_d    = cnt_q;
        rexp_d   = rexp_q;
        res_d    = res_q;
        inv_d    = inv_q;

        if (accept) begin
            x_d      = io.x;
            loaded_d = 1'b0;
            rem_d    = '0;
            root_d   = '0;
            cnt_d    = '0;
        end else if (state_q == ITER) begin
            if (!loaded_q) begin
                rad_d    = rad_init;
                rexp_d   = rexp_init;
                loaded_d = 1'b1;
            end else begin
                rad_d  = rad_q << 2;
                rem_d  = take ? (M + 3)'(acc - {2'b00, sub}) : acc[M+2:0];
                root_d = root_next;
                cnt_d  = cnt_q + CW'(1);
                // The root MSB is always set, so only the low M bits become the stored mantissa.
                if (cnt_q == LAST) begin
                    res_d = {1'b0, rexp_q, root_next[M-1:0]};
                    inv_d = 1'b0;
                end
            end
        end else if (state_q == SPEC) begin
            res_d = spec_res;
            inv_d = spec_inv;
        end
    end

    always_comb begin
        io.finish    = (state_q == DONE);
        io.computing = (state_q == ITER) || (state_q == SPEC);
        io.res       = res_q;
        io.invalid   = inv_q;
    end
endmodule

// File: tb/tb_fphub_sqrt_iter.sv
// Directed bench for fphub_sqrt_iter: hand-computed roots, special operands, handshake and reset cases.
module tb_fphub_sqrt_iter;
    logic clk;
    logic rst_l;
    int   checks;
    int   failures;
    int   n;

    fphub_sqrt_iter_if #(.M(23), .E(8)) io ();

    fphub_sqrt_iter #(.M(23), .E(8)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drives a one-cycle start request; returns just after the accepting edge.
    task automatic start_op(input logic [31:0] xin);
        @(negedge clk);
        io.x     = xin;
        io.start = 1'b1;
        @(posedge clk);
        #1 io.start = 1'b0;
    endtask

    task automatic wait_finish(input int n0, output int cnt);
        cnt = n0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!io.finish && cnt < 200);
    endtask

    task automatic applyStimulus(input string tag, input logic [31:0] xin, input int exp_lat,
                                 input logic [31:0] exp_res, input logic exp_inv);
        int lat;
        start_op(xin);
        checkOutput({tag, "_busy"}, 32'(io.computing), 32'd1);
        wait_finish(0, lat);
        checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_res"}, io.res, exp_res);
        checkOutput({tag, "_inv"}, 32'(io.invalid), 32'(exp_inv));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_l    = 1'b0;
        io.start = 1'b0;
        io.x     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_l = 1'b1;

        repeat (10) @(posedge clk);
        #1;
        checkOutput("idle_res",  io.res, 32'h0000_0000);
        checkOutput("idle_fin",  32'(io.finish), 32'd0);
        checkOutput("idle_busy", 32'(io.computing), 32'd0);
        checkOutput("idle_inv",  32'(io.invalid), 32'd0);

        applyStimulus("one",   32'h3F80_0000, 25, 32'h3F80_0000, 1'b0);
        @(posedge clk); #1;
        checkOutput("done_to_idle", 32'(io.finish), 32'd0);
        applyStimulus("two",   32'h4000_0000, 25, 32'h3FB5_04F3, 1'b0);
        applyStimulus("four",  32'h4080_0000, 25, 32'h4000_0000, 1'b0);
        applyStimulus("nine",  32'h4110_0000, 25, 32'h4040_0000, 1'b0);
        applyStimulus("neg",   32'hC080_0000, 1,  32'h7FC0_0000, 1'b1);
        applyStimulus("nzero", 32'h8000_0000, 1,  32'h8000_0000, 1'b0);
        applyStimulus("inf",   32'h7F80_0000, 1,  32'h7F80_0000, 1'b0);
        applyStimulus("nan",   32'h7F80_0001, 1,  32'h7FC0_0000, 1'b1);

        // Second request mid-flight must be ignored.
        start_op(32'h4000_0000);
        repeat (9) @(posedge clk);
        #1;
        io.x     = 32'h3F80_0000;
        io.start = 1'b1;
        @(posedge clk);
        #1 io.start = 1'b0;
        checkOutput("ign_busy", 32'(io.computing), 32'd1);
        wait_finish(10, n);
        checkOutput("ign_lat", 32'(n), 32'd25);
        checkOutput("ign_res", io.res, 32'h3FB5_04F3);

        // Back-to-back: start raised during the DONE cycle.
        io.x     = 32'h4080_0000;
        io.start = 1'b1;
        @(posedge clk);
        #1 io.start = 1'b0;
        checkOutput("b2b_busy", 32'(io.computing), 32'd1);
        checkOutput("b2b_fin",  32'(io.finish), 32'd0);
        wait_finish(0, n);
        checkOutput("b2b_lat", 32'(n), 32'd25);
        checkOutput("b2b_res", io.res, 32'h4000_0000);

        // Asynchronous reset in the middle of an operation.
        start_op(32'h3F80_0000);
        repeat (11) @(posedge clk);
        #1 rst_l = 1'b0;
        #1;
        checkOutput("rst_res",  io.res, 32'h0000_0000);
        checkOutput("rst_fin",  32'(io.finish), 32'd0);
        checkOutput("rst_busy", 32'(io.computing), 32'd0);
        checkOutput("rst_inv",  32'(io.invalid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_l = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("post_rst_idle", 32'(io.computing), 32'd0);
        applyStimulus("post_rst", 32'h3F80_0000, 25, 32'h3F80_0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fphub_sqrt_iter.md
Name: fphub_sqrt_iter

Overview:
- Parametrised, sequential square-root unit for the HUB floating-point format, one root bit per clock, using a restoring digit recurrence.
- Generalised over mantissa width M and exponent width E.
- Adds full special-case handling (zero, negative, Inf, NaN), an invalid flag, a fast path for special operands, and a clean start/finish handshake.
- Sits beside the other FPHUB arithmetic units and is driven by the same issue logic.

Parameters:
- M, 23, stored mantissa bits (M >= 2)
- E, 8, exponent bits (E >= 3)
- T, M+E (localparam), MSB index of operand/result
- BIAS, 2^(E-1)-1 (localparam), exponent bias
- IT, M+1 (localparam), recurrence iterations

Ports:
- clk  in  1  clock, rising edge
- rst_l  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when accepting (IDLE or DONE)
- x  in  T+1  operand {sign, exp[E], man[M]}; HUB value (-1)^s * 1.man1 * 2^(exp-BIAS)
- res  out  T+1  result, same format
- finish  out  1  one-cycle pulse, res valid
- computing  out  1  high while an operation is in flight
- invalid  out  1  valid with finish; 1 for negative nonzero or NaN input

Behaviour:
- Interface: one clock clk; reset rst_l is asynchronous, active-low.
- Reset (any time, including mid-operation) forces:
  - FSM to IDLE
  - res = 0, finish = 0, computing = 0, invalid = 0
  - all internal registers cleared
  - any in-flight operation is discarded.
- FSM states: IDLE, ITER, SPEC, DONE.
  - IDLE/DONE with start=1: classify x and go to SPEC (special operand) or ITER (normal operand).
  - start while in ITER or SPEC is ignored.
  - DONE without start goes to IDLE.
- Outputs by state:
  - computing = 1 in ITER and SPEC.
  - finish = 1 only in DONE.
  - res and invalid hold their last values until the next DONE.
- Latency, counted from the accepting edge:
  - normal operand: finish high after exactly IT+1 edges (M+2; 25 for defaults)
  - special operand: finish high after exactly 1 edge.
- Back-to-back: start in DONE is accepted; the new operation's computing rises on the next edge.
- Classification (priority order):
  1. exp=all-ones, man!=0 (NaN): res = {0, all-ones, 1, 0...}, invalid=1.
  2. exp=0 (zero; HUB has no subnormals): res = {sign, 0...}, invalid=0.
  3. sign=1: res = canonical NaN, invalid=1.
  4. exp=all-ones, man=0: res = +Inf, invalid=0.
  5. Otherwise: normal operand.
- Normal operand setup:
  - Let e = exp - BIAS (signed E+1 bits) and odd = e[0].
  - Result exponent = ((e - odd) >>> 1) + BIAS; this never overflows or underflows.
  - S = {1, man, 1} (M+2 bits).
  - Radicand X = S << (M-1+odd), 2M+2 bits.
- Recurrence:
  - Restoring integer square root over IT cycles, consuming 2 radicand bits per cycle, MSB pair first.
  - Partial remainder is M+3 bits, unsigned.
  - Root register q is M+1 bits.
  - Each cycle: trial = (rem<<2 | next pair) - (q<<2 | 01). If non-negative, rem = trial and bit = 1; else rem is shifted and bit = 0. q = (q<<1) | bit.
  - Iteration counter runs 0..IT-1; ITER exits when the counter reaches IT-1.
- Packing:
  - q MSB is always 1.
  - res = {0, result exponent, q[M-1:0]}. Truncation is correct rounding, since HUB's implicit ILSB provides round-to-nearest.
  - invalid = 0.
- No combinational path from start or x to any output.

Test Plan:
- Reset released, idle, start=0 for 10 cycles -> res=0x00000000, finish=0, computing=0, invalid=0.
- x=0x3F800000 (1.0), start pulse -> computing high 25 cycles, finish on edge 25, res=0x3F800000, invalid=0.
- x=0x40000000 (2.0, odd exponent) -> res=0x3FB504F3 on edge 25; x=0x40800000 (4.0) -> res=0x40000000.
- Special operands, each with finish on edge 1:
  - x=0xC0800000 -> res=0x7FC00000, invalid=1
  - x=0x80000000 -> res=0x80000000, invalid=0
  - x=0x7F800000 -> res=0x7F800000
  - x=0x7F800001 -> res=0x7FC00000, invalid=1
- Start 0x40000000, re-assert start with 0x3F800000 at edge 10 -> second request ignored, res=0x3FB504F3 at edge 25. Then start in the DONE cycle -> accepted, next finish 25 edges later.
- Assert rst_l=0 at edge 12 of an operation -> outputs zero immediately and FSM in IDLE. After release, a new start with 1.0 yields 0x3F800000 with nominal latency.
